max_pool_seq: RTL and testbench

- Sequences a combinational NUM_DATA-way unsigned max-reduction tree to perform max pooling over a window of several input beats.
- Each beat is a NUM_DATA-element vector. The block drives the vector into the external tree and folds the tree result into a running maximum.
- When the window completes, the block emits one pooled value on a valid/ready output.
- Sits between the NPU activation buffer read stream and the pooling writeback path.

---
 rtl/max_pool_seq.sv | 112 +++++++++++
 tb/tb_max_pool_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_seq.sv
// Max pooling sequencer: streams NUM_DATA-wide beats through an external
// combinational max tree and folds each tree result into a running maximum.
// After a configured number of beats it presents one pooled value on a
// valid/ready output.
module max_pool_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_DATA   = 16,
  parameter int unsigned MAX_BEATS  = 64,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           cfg_num_beats,
  output logic                           cfg_err,
  output logic                           busy,
  input  logic                           abort,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] in_data,
  output logic [DATA_WIDTH*NUM_DATA-1:0] tree_data,
  input  logic [DATA_WIDTH-1:0]          tree_max,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data
);

  localparam logic [CNT_WIDTH-1:0] MaxBeats = CNT_WIDTH'(MAX_BEATS);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  len_legal;

  assign len_legal = (cfg_num_beats != '0) && (cfg_num_beats <= MaxBeats);

  // Next-state: window setup, per-beat fold and result handoff; abort wins over everything.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!abort && start) begin
          if (len_legal) begin
            len_d   = cfg_num_beats;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = StRun;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          // First beat seeds the accumulator; equal values leave it untouched.
          if (cnt_q == '0 || tree_max > acc_q) begin
            acc_d = tree_max;
          end
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q == len_q - CNT_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (abort || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tree_data = in_data;
  assign in_ready  = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);
  assign out_data  = out_valid ? acc_q : '0;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_max_pool_seq.sv
// Self-checking bench for max_pool_seq: models the external max tree,
// scores pooled results through an expected-value queue, and walks a
// table of windows plus hand-written abort/reset/config-error sequences.
module tb_max_pool_seq;

  localparam int DW = 8;
  localparam int ND = 16;
  localparam int CW = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [CW-1:0]      cfg_num_beats;
  logic               cfg_err;
  logic               busy;
  logic               abort;
  logic               in_valid;
  logic               in_ready;
  logic [DW*ND-1:0]   in_data;
  logic [DW*ND-1:0]   tree_data;
  logic [DW-1:0]      tree_max;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;

  max_pool_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_num_beats (cfg_num_beats),
    .cfg_err       (cfg_err),
    .busy          (busy),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .tree_data     (tree_data),
    .tree_max      (tree_max),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  always #5 clk = ~clk;

  // External tree model: unsigned max over the 16 lanes.
  always_comb begin
    tree_max = '0;
    for (int k = 0; k < ND; k++) begin
      if (tree_data[k*DW +: DW] > tree_max) tree_max = tree_data[k*DW +: DW];
    end
  end

  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts accepted beats and scores each output handshake.
  always @(negedge clk) begin
    if (reset && !abort) begin
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hDEAD);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*ND-1:0] mk_beat(input logic [DW-1:0] mx);
    logic [DW*ND-1:0] d;
    int pos;
    pos = $urandom_range(0, ND - 1);
    for (int k = 0; k < ND; k++) begin
      d[k*DW +: DW] = (k == pos) ? mx : DW'($urandom_range(0, int'(mx)));
    end
    return d;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 0);
  endtask

  // Starts at posedge+1, ends at posedge+1 with the block in RUN.
  task automatic start_win(input int n);
    start = 1'b1;
    cfg_num_beats = CW'(n);
    step();
    start = 1'b0;
    @(negedge clk);
    check("start_in_ready", 32'(in_ready), 1);
    check("start_busy", 32'(busy), 1);
    step();
  endtask

  task automatic send_beat(input logic [DW*ND-1:0] d, input int nbub);
    int t;
    repeat (nbub) step();
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      step();
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("beat_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Entered at a negedge; holds out_ready low for 'stall' cycles, then handshakes.
  task automatic wait_out(input int stall);
    int t;
    int acc0;
    logic [DW-1:0] held;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check("out_timeout", 0, 1);
      return;
    end
    held = out_data;
    acc0 = n_acc;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'(held));
      check("done_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    if (stall > 0) check("stall_no_accept", 32'(n_acc), 32'(acc0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("post_busy", 32'(busy), 0);
    check("post_out_valid", 32'(out_valid), 0);
    check("post_out_data", 32'(out_data), 0);
    check("idle_in_ready", 32'(in_ready), 0);
    step();
  endtask

  task automatic run_window(input int n, input logic [DW*ND-1:0] beats[$],
                            input logic [DW-1:0] exp, input int nbub, input int stall);
    int acc0;
    exp_q.push_back(exp);
    start_win(n);
    acc0 = n_acc;
    for (int i = 0; i < n; i++) send_beat(beats[i], $urandom_range(0, nbub));
    @(negedge clk);
    check("latency_out_valid", 32'(out_valid), 1);
    check("beats_accepted", 32'(n_acc - acc0), 32'(n));
    wait_out(stall);
  endtask

  typedef struct {
    int            n;
    logic [DW-1:0] mx[8];
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW*ND-1:0] bq[$];
    logic [DW*ND-1:0] d;

    tbl[0] = '{4, '{8'h10, 8'hFE, 8'h33, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 8'hFE};
    tbl[1] = '{2, '{8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h05};
    tbl[2] = '{5, '{8'h7F, 8'h80, 8'h01, 8'h80, 8'h7E, 8'h00, 8'h00, 8'h00}, 8'h80};
    tbl[3] = '{3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00};
    tbl[4] = '{2, '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'hFF};
    tbl[5] = '{8, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h70}, 8'h77};
    tbl[6] = '{1, '{8'h9C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h9C};
    tbl[7] = '{3, '{8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'hAA};

    reset = 1'b0;
    start = 1'b0;
    cfg_num_beats = '0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_idle_zero("reset");
    check("tree_passthrough", 32'(tree_data == in_data), 1);
    step();
    reset = 1'b1;
    step();

    // Single-beat window, lanes 0..15.
    for (int k = 0; k < ND; k++) d[k*DW +: DW] = DW'(k);
    bq = {};
    bq.push_back(d);
    run_window(1, bq, 8'h0F, 0, 0);

    // Table of windows with random bubbles and output stalls.
    for (int i = 0; i < 8; i++) begin
      bq = {};
      for (int b = 0; b < tbl[i].n; b++) bq.push_back(mk_beat(tbl[i].mx[b]));
      run_window(tbl[i].n, bq, tbl[i].exp, 3, i % 3);
    end

    // Maximum window length, all lanes 0xFF, stalled output.
    bq = {};
    for (int b = 0; b < 64; b++) bq.push_back({ND{8'hFF}});
    run_window(64, bq, 8'hFF, 0, 5);

    // Illegal lengths pulse cfg_err once each and stay idle.
    for (int i = 0; i < 2; i++) begin
      start = 1'b1;
      cfg_num_beats = (i == 0) ? CW'(0) : CW'(65);
      step();
      start = 1'b0;
      @(negedge clk);
      check("cfg_err_pulse", 32'(cfg_err), 1);
      check("cfg_err_busy", 32'(busy), 0);
      check("cfg_err_in_ready", 32'(in_ready), 0);
      step();
      @(negedge clk);
      check("cfg_err_clear", 32'(cfg_err), 0);
      check("cfg_err_idle", 32'(busy), 0);
      step();
    end

    // Abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    cfg_num_beats = CW'(4);
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", 32'(busy), 0);
    check("idle_abort_cfg_err", 32'(cfg_err), 0);
    step();

    // Abort mid-window together with a valid beat, then a clean window.
    start_win(8);
    for (int b = 0; b < 3; b++) send_beat(mk_beat(8'hF0), 0);
    in_valid = 1'b1;
    in_data = {ND{8'hFF}};
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    step();
    repeat (3) step();
    @(negedge clk);
    check("abort_no_output", 32'(out_valid), 0);
    step();
    bq = {};
    bq.push_back(mk_beat(8'h05));
    bq.push_back(mk_beat(8'h04));
    run_window(2, bq, 8'h05, 1, 1);

    // Abort in DONE wins over a simultaneous output handshake.
    start_win(1);
    send_beat(mk_beat(8'h42), 0);
    abort = 1'b1;
    out_ready = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("done_abort_valid", 32'(out_valid), 0);
    check("done_abort_busy", 32'(busy), 0);
    step();

    // Reset mid-RUN.
    start_win(4);
    send_beat(mk_beat(8'hC3), 0);
    send_beat(mk_beat(8'h21), 0);
    reset = 1'b0;
    step();
    @(negedge clk);
    check_idle_zero("rst_run");
    step();
    reset = 1'b1;
    step();

    // Reset in DONE while output is stalled.
    start_win(2);
    send_beat(mk_beat(8'h77), 0);
    send_beat(mk_beat(8'h99), 0);
    @(negedge clk);
    check("rst_done_pre_valid", 32'(out_valid), 1);
    check("rst_done_pre_data", 32'(out_data), 32'h99);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check_idle_zero("rst_done");
    step();
    reset = 1'b1;
    step();

    // Fresh window after reset.
    bq = {};
    for (int b = 0; b < tbl[0].n; b++) bq.push_back(mk_beat(tbl[0].mx[b]));
    run_window(tbl[0].n, bq, tbl[0].exp, 2, 2);

    repeat (2) step();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
